// File: rtl/vec_mem_unit_pkg.sv
// Shared vector-unit definitions: lane count, default widths, lane type and
// the load/store unit state encoding.
package vec_pkg;

  localparam int VEC_LANES     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_REG_SEL_W = 3;

  typedef logic [DEF_DATA_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_DRAIN,
    LD_WB,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/vec_mem_unit.sv
// Vector load/store unit: moves 4 byte lanes between a byte-wide synchronous
// memory and the vector register file, one request in flight at a time.
module vec_mem_unit
  import vec_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int REG_SEL_W = DEF_REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqIsStore,
  input  logic [ADDR_W-1:0]    reqAddr,
  input  logic [REG_SEL_W-1:0] reqReg,
  input  logic [DATA_W-1:0]    storeData_0,
  input  logic [DATA_W-1:0]    storeData_1,
  input  logic [DATA_W-1:0]    storeData_2,
  input  logic [DATA_W-1:0]    storeData_3,
  output logic [ADDR_W-1:0]    memAddr,
  output logic                 memRdEn,
  output logic                 memWrEn,
  output logic [DATA_W-1:0]    memWrData,
  input  logic [DATA_W-1:0]    memRdData,
  output logic                 regWrEn,
  output logic [REG_SEL_W-1:0] regToWrite,
  output logic [DATA_W-1:0]    regWriteData_0,
  output logic [DATA_W-1:0]    regWriteData_1,
  output logic [DATA_W-1:0]    regWriteData_2,
  output logic [DATA_W-1:0]    regWriteData_3,
  output logic                 done
);

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [REG_SEL_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]      ld_buf_q [VEC_LANES];
  logic [DATA_W-1:0]      ld_buf_d [VEC_LANES];
  logic [DATA_W-1:0]      st_buf_q [VEC_LANES];
  logic [DATA_W-1:0]      st_buf_d [VEC_LANES];
  logic [ADDR_W-1:0]      lane_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      reg_q    <= '0;
      ld_buf_q <= '{default: '0};
      st_buf_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      reg_q    <= reg_d;
      ld_buf_q <= ld_buf_d;
      st_buf_q <= st_buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    ld_buf_d  = ld_buf_q;
    st_buf_d  = st_buf_q;
    reqReady  = 1'b0;
    memAddr   = '0;
    memRdEn   = 1'b0;
    memWrEn   = 1'b0;
    memWrData = '0;
    regWrEn   = 1'b0;
    done      = 1'b0;
    // Wraps modulo 2^ADDR_W by width truncation.
    lane_addr = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};

    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          addr_d   = reqAddr;
          reg_d    = reqReg;
          st_buf_d = '{storeData_0, storeData_1, storeData_2, storeData_3};
          cnt_d    = '0;
          state_d  = reqIsStore ? ST_WRITE : LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        memRdEn = 1'b1;
        memAddr = lane_addr;
        // Read data lags the strobe by one cycle, so it belongs to the previous lane.
        if (cnt_q != 2'd0) begin
          ld_buf_d[cnt_q - 2'd1] = memRdData;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        ld_buf_d[3] = memRdData;
        state_d     = LD_WB;
      end
      LD_WB: begin
        regWrEn = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      ST_WRITE: begin
        memWrEn   = 1'b1;
        memAddr   = lane_addr;
        memWrData = st_buf_q[cnt_q];
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign regToWrite     = reg_q;
  assign regWriteData_0 = ld_buf_q[0];
  assign regWriteData_1 = ld_buf_q[1];
  assign regWriteData_2 = ld_buf_q[2];
  assign regWriteData_3 = ld_buf_q[3];

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench for vec_mem_unit with a byte-wide synchronous memory model
// and a small register-file model capturing write-backs.
module tb_vec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  logic [15:0] reqAddr;
  logic [2:0]  reqReg;
  logic [7:0]  storeData_0, storeData_1, storeData_2, storeData_3;
  logic [15:0] memAddr;
  logic        memRdEn;
  logic        memWrEn;
  logic [7:0]  memWrData;
  logic [7:0]  memRdData;
  logic        regWrEn;
  logic [2:0]  regToWrite;
  logic [7:0]  regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [65536];
  logic [7:0]  mem_rd_q = 8'h00;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [7:0]  poke_data = 8'h00;
  logic [31:0] rf [8];
  int          wr_pulses = 0;
  int          done_pulses = 0;

  vec_mem_unit dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqIsStore(reqIsStore),
    .reqAddr(reqAddr), .reqReg(reqReg),
    .storeData_0(storeData_0), .storeData_1(storeData_1),
    .storeData_2(storeData_2), .storeData_3(storeData_3),
    .memAddr(memAddr), .memRdEn(memRdEn), .memWrEn(memWrEn),
    .memWrData(memWrData), .memRdData(memRdData),
    .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWriteData_0(regWriteData_0), .regWriteData_1(regWriteData_1),
    .regWriteData_2(regWriteData_2), .regWriteData_3(regWriteData_3),
    .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory; the bench preloads it through the poke port.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (memWrEn) mem[memAddr] <= memWrData;
    if (memRdEn) mem_rd_q <= mem[memAddr];
  end
  assign memRdData = mem_rd_q;

  always @(posedge clk) begin
    if (regWrEn) rf[regToWrite] <= {regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3};
    if (regWrEn) wr_pulses <= wr_pulses + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Issues one load and checks every cycle up to write-back; optionally
  // raises a follow-on request in cycle 1 that must be held off.
  task automatic run_load(input logic [15:0] base, input logic [2:0] rsel,
                          input logic [31:0] exp, input string tag,
                          input bit next_valid, input logic [15:0] next_addr,
                          input logic [2:0] next_reg);
    logic [15:0] a;
    reqValid = 1'b1; reqIsStore = 1'b0; reqAddr = base; reqReg = rsel;
    tick();
    reqValid = next_valid; reqAddr = next_addr; reqReg = next_reg;
    for (int c = 1; c <= 4; c++) begin
      a = base + 16'(c - 1);
      vectors++;
      if ({memRdEn, memWrEn, reqReady, regWrEn, done, memAddr} !== {5'b10000, a}) begin
        miscompares++;
        $display("[TB] FAIL %s issue c%0d: got rd=%b wr=%b rdy=%b rwe=%b done=%b addr=%h expected rd=1 wr=0 rdy=0 rwe=0 done=0 addr=%h",
                 tag, c, memRdEn, memWrEn, reqReady, regWrEn, done, memAddr, a);
      end
      tick();
    end
    vectors++;
    if ({memRdEn, memWrEn, reqReady, regWrEn, done} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL %s drain: got rd=%b wr=%b rdy=%b rwe=%b done=%b expected all 0",
               tag, memRdEn, memWrEn, reqReady, regWrEn, done);
    end
    tick();
    vectors++;
    if ({memRdEn, memWrEn, reqReady, regWrEn, done, regToWrite} !== {5'b00011, rsel}) begin
      miscompares++;
      $display("[TB] FAIL %s wb ctrl: got rd=%b wr=%b rdy=%b rwe=%b done=%b reg=%0d expected rwe=1 done=1 reg=%0d",
               tag, memRdEn, memWrEn, reqReady, regWrEn, done, regToWrite, rsel);
    end
    vectors++;
    if ({regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3} !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s wb data: got %h expected %h", tag,
               {regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3}, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; reqValid = 1'b0; reqIsStore = 1'b0; reqAddr = '0; reqReg = '0;
    storeData_0 = '0; storeData_1 = '0; storeData_2 = '0; storeData_3 = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({reqReady, regWrEn, memRdEn, memWrEn, done} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL reset ctrl: got rdy=%b rwe=%b rd=%b wr=%b done=%b expected 10000",
               reqReady, regWrEn, memRdEn, memWrEn, done);
    end
    vectors++;
    if ({regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset data: got %h expected 00000000",
               {regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3});
    end
  endtask

  task automatic test_load();
    poke(16'h0010, 8'hDE); poke(16'h0011, 8'hAD); poke(16'h0012, 8'hBE); poke(16'h0013, 8'hEF);
    run_load(16'h0010, 3'd1, 32'hDEADBEEF, "load", 1'b0, 16'h0000, 3'd0);
    vectors++;
    if (rf[1] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL load regfile r1: got %h expected DEADBEEF", rf[1]);
    end
  endtask

  task automatic test_store();
    logic [7:0] exp_d [4];
    exp_d = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
    storeData_0 = 8'h1A; storeData_1 = 8'h2B; storeData_2 = 8'h3C; storeData_3 = 8'h4D;
    reqValid = 1'b1; reqIsStore = 1'b1; reqAddr = 16'h0100; reqReg = 3'd5;
    tick();
    reqValid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if ({memWrEn, memRdEn, reqReady, regWrEn, done, memAddr, memWrData} !==
          {4'b1000, (c == 4), 16'h0100 + 16'(c - 1), exp_d[c-1]}) begin
        miscompares++;
        $display("[TB] FAIL store c%0d: got wr=%b rd=%b rdy=%b rwe=%b done=%b addr=%h data=%h expected wr=1 done=%0d addr=%h data=%h",
                 c, memWrEn, memRdEn, reqReady, regWrEn, done, memAddr, memWrData,
                 (c == 4), 16'h0100 + 16'(c - 1), exp_d[c-1]);
      end
      if (c == 2) begin
        storeData_0 = 8'h00; storeData_1 = 8'h00; storeData_2 = 8'h00; storeData_3 = 8'h00;
      end
      tick();
    end
    vectors++;
    if ({reqReady, memWrEn, done} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL store after: got rdy=%b wr=%b done=%b expected 100", reqReady, memWrEn, done);
    end
    vectors++;
    if ({mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]} !== 32'h1A2B3C4D) begin
      miscompares++;
      $display("[TB] FAIL store readback: got %h expected 1A2B3C4D",
               {mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]});
    end
    vectors++;
    if ({regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL store keeps load buf: got %h expected DEADBEEF",
               {regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3});
    end
  endtask

  task automatic test_wrap();
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
    run_load(16'hFFFE, 3'd3, 32'h11223344, "wrap", 1'b0, 16'h0000, 3'd0);
  endtask

  task automatic test_back_to_back();
    int start_wr;
    start_wr = wr_pulses;
    poke(16'h0020, 8'hA0); poke(16'h0021, 8'hA1); poke(16'h0022, 8'hA2); poke(16'h0023, 8'hA3);
    run_load(16'h0010, 3'd4, 32'hDEADBEEF, "b2b first", 1'b1, 16'h0020, 3'd7);
    vectors++;
    if (reqReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b ready after wb: got %b expected 1", reqReady);
    end
    run_load(16'h0020, 3'd7, 32'hA0A1A2A3, "b2b second", 1'b0, 16'h0000, 3'd0);
    vectors++;
    if (wr_pulses - start_wr !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b regWrEn count: got %0d expected 2", wr_pulses - start_wr);
    end
  endtask

  task automatic test_reset_mid();
    int start_wr, start_done;
    poke(16'h0030, 8'h55); poke(16'h0031, 8'h66); poke(16'h0032, 8'h77); poke(16'h0033, 8'h88);
    start_wr = wr_pulses;
    start_done = done_pulses;
    reqValid = 1'b1; reqIsStore = 1'b0; reqAddr = 16'h0030; reqReg = 3'd2;
    tick();
    reqValid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({reqReady, regWrEn, done, memRdEn, memWrEn} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL mid-reset ctrl: got rdy=%b rwe=%b done=%b rd=%b wr=%b expected 10000",
               reqReady, regWrEn, done, memRdEn, memWrEn);
    end
    vectors++;
    if ({regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid-reset buf: got %h expected 00000000",
               {regWriteData_0, regWriteData_1, regWriteData_2, regWriteData_3});
    end
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if ((wr_pulses - start_wr) !== 0 || (done_pulses - start_done) !== 0) begin
      miscompares++;
      $display("[TB] FAIL mid-reset pulses: got rwe=%0d done=%0d expected 0 0",
               wr_pulses - start_wr, done_pulses - start_done);
    end
    poke(16'h0030, 8'h99); poke(16'h0031, 8'hAA); poke(16'h0032, 8'hBB); poke(16'h0033, 8'hCC);
    run_load(16'h0030, 3'd2, 32'h99AABBCC, "post-reset", 1'b0, 16'h0000, 3'd0);
    vectors++;
    if (rf[2] !== 32'h99AABBCC) begin
      miscompares++;
      $display("[TB] FAIL post-reset regfile r2: got %h expected 99AABBCC", rf[2]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
Vector load/store unit that sits between data memory and the vector register file.
- Loads: fetches 4 consecutive bytes from a byte-wide synchronous memory, assembles them into lanes 0..3, and drives the register file write port for one cycle.
- Stores: samples the 4 lanes from register file read port 2 at request accept, then writes them to 4 consecutive memory addresses.
- One request in flight at a time; valid/ready request handshake.

Parameters:
DATA_W, 8, lane width in bits (also memory data width)
ADDR_W, 16, byte address width
REG_SEL_W, 3, vector register select width (8 registers)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
reqValid  in  1  request present
reqReady  out  1  unit idle; request accepted when reqValid && reqReady at a rising edge
reqIsStore  in  1  1 = store, 0 = load
reqAddr  in  ADDR_W  base byte address; lane k uses reqAddr+k
reqReg  in  REG_SEL_W  load destination register
storeData_0..storeData_3  in  DATA_W each  store lanes (from regfile reg2Out_0..3), sampled at accept
memAddr  out  ADDR_W  memory address
memRdEn  out  1  memory read strobe; memRdData valid the following cycle
memWrEn  out  1  memory write strobe
memWrData  out  DATA_W  memory write data
memRdData  in  DATA_W  memory read data
regWrEn  out  1  register file write enable
regToWrite  out  REG_SEL_W  register file write select
regWriteData_0..regWriteData_3  out  DATA_W each  assembled load lanes
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE, lane counter 0.
  - All outputs 0 except reqReady=1.
  - Load buffer, store buffer, latched address and latched register all cleared.
- States: IDLE, LD_ISSUE, LD_DRAIN, LD_WB, ST_WRITE.
- IDLE:
  - reqReady=1.
  - On accept: latch reqAddr, reqReg and storeData_0..3.
  - reqIsStore=0 -> LD_ISSUE; reqIsStore=1 -> ST_WRITE. Lane counter starts at 0.
- Timing: cycle 1 is the cycle after the accept edge.
- Load sequence:
  - LD_ISSUE (cycles 1-4): memRdEn=1, memAddr=base+cnt.
  - From cycle 2 on: capture memRdData into lane cnt-1.
  - At cnt=3 -> LD_DRAIN.
  - LD_DRAIN (cycle 5): capture lane 3; memRdEn=0 -> LD_WB.
  - LD_WB (cycle 6): regWrEn=1, regToWrite=latched reg, done=1 -> IDLE.
  - Accept to regWrEn = 6 cycles.
- Store sequence:
  - ST_WRITE (cycles 1-4): memWrEn=1, memAddr=base+cnt, memWrData=latched lane cnt.
  - done=1 together with the lane 3 write (cycle 4) -> IDLE; reqReady=1 in cycle 5.
- reqReady=0 in every non-IDLE state. reqValid while busy is ignored, not queued.
- regWriteData_0..3 always show the load buffer. Lanes are overwritten only by load captures; the buffer holds between loads.
- Address arithmetic: modulo 2^ADDR_W; wraps FFFF -> 0000 with no error.
- memRdEn and memWrEn are never high in the same cycle. Both are 0 in IDLE, LD_DRAIN and LD_WB.
- Register 0 is an ordinary destination.
- Reset mid-operation:
  - Takes effect at the next edge and returns to IDLE.
  - A partially assembled load never writes back; no regWrEn or done is issued for the aborted request.
  - Memory writes already performed by an aborted store stay in memory.
- The store source registers must be selected on rSel2 by the upstream logic at accept. Later changes on storeData_0..3 have no effect on the request in flight.

Decomposition:
- Shared package vec_pkg holds:
  - constant VEC_LANES=4
  - lane typedef logic [DATA_W-1:0]
  - state enum {IDLE, LD_ISSUE, LD_DRAIN, LD_WB, ST_WRITE}
  - default DATA_W/ADDR_W/REG_SEL_W constants shared with vecRegisterFile.
- No sub-module is needed: one FSM plus a 2-bit lane counter and the lane buffers.

Test Plan:
1. Reset held 2 cycles, then released.
   - Required: reqReady=1; regWrEn, memRdEn, memWrEn, done = 0; all regWriteData = 0.
2. Memory bytes 0x0010..0x0013 = DE AD BE EF; load to reg 1 at base 0x0010.
   - Cycles 1-4: memRdEn=1 with addresses 0010, 0011, 0012, 0013.
   - Cycle 6: regWrEn=1, regToWrite=1, data DE/AD/BE/EF, done=1.
   - Attached vecRegisterFile with rSel1=1 then reads DE AD BE EF.
3. Store from storeData 1A 2B 3C 4D to base 0x0100.
   - Cycles 1-4: memWrEn=1 with 0100/1A, 0101/2B, 0102/3C, 0103/4D; done in cycle 4.
   - Memory readback matches.
   - storeData changed to 00 in cycle 2: the written values are unchanged.
4. Load at base 0xFFFE.
   - Addresses issued: FFFE, FFFF, 0000, 0001.
   - Lanes hold the bytes at those addresses, in that order.
5. Second request (load to reg 7) held valid from cycle 1 of a first load.
   - Not accepted until the cycle after the first load's LD_WB.
   - Then completes with regToWrite=7; exactly one regWrEn per load.
6. Reset asserted in cycle 3 of a load to reg 2.
   - No regWrEn or done; IDLE and reqReady=1 after the reset edge.
   - A following load to reg 2 completes correctly with fresh data.
